// File: rtl/word_chunk_pkg.sv
// Shared defaults, sizing helpers and FSM state type for the 64-bit word chunker.
package word_chunk_pkg;

    localparam int unsigned WORD_W_DEF  = 64;
    localparam int unsigned CHUNK_W_DEF = 5;
    localparam int unsigned CNT_W_DEF   = 8;

    function automatic int unsigned num_chunks(input int unsigned word_w,
                                               input int unsigned chunk_w);
        return (word_w + chunk_w - 1) / chunk_w;
    endfunction

    // A one-chunk word still needs a 1-bit index to keep widths legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

endpackage

// File: rtl/word_chunker.sv
// Serialises one accepted word MSB-first into CHUNK_W-bit chunks for a free-running
// downstream shift register; drives zeros whenever no chunk is valid.
module word_chunker
    import word_chunk_pkg::*;
#(
    parameter int unsigned WORD_W  = WORD_W_DEF,
    parameter int unsigned CHUNK_W = CHUNK_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    output logic [CHUNK_W-1:0] out_chunk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [CNT_W-1:0]   words_sent
);

    localparam int unsigned NUM_CHUNKS = num_chunks(WORD_W, CHUNK_W);
    localparam int unsigned HOLD_W     = NUM_CHUNKS * CHUNK_W;
    localparam int unsigned IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (CHUNK_W < 1 || CHUNK_W > WORD_W) begin : g_bad_chunk_w
        $error("word_chunker: CHUNK_W must be in 1..WORD_W");
    end

    state_e              r_state, w_state_d;
    logic [HOLD_W-1:0]   r_hold,  w_hold_d;
    logic [IDX_W-1:0]    r_idx,   w_idx_d;
    logic [CNT_W-1:0]    r_words, w_words_d;

    logic                w_send;
    logic                w_last;
    logic                w_take;
    logic [HOLD_W-1:0]   w_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_idx   <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_state_d;
            r_hold  <= w_hold_d;
            r_idx   <= w_idx_d;
            r_words <= w_words_d;
        end
    end

    // Zero-extension places the pad bits at the MSB end of the hold register.
    assign w_load = HOLD_W'(in_word);
    assign w_send = (r_state == SEND);
    assign w_last = w_send && (r_idx == LAST_IDX);
    assign w_take = w_send && out_ready;

    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold;
        w_idx_d   = r_idx;
        w_words_d = r_words;
        in_ready  = 1'b0;

        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_hold_d  = w_load;
                    w_idx_d   = '0;
                    w_state_d = SEND;
                end
            end
            SEND: begin
                if (w_take && !w_last) begin
                    w_hold_d = r_hold << CHUNK_W;
                    w_idx_d  = r_idx + IDX_W'(1);
                end else if (w_take) begin
                    in_ready  = 1'b1;
                    w_words_d = r_words + CNT_W'(1);
                    w_idx_d   = '0;
                    if (in_valid) begin
                        w_hold_d = w_load;
                    end else begin
                        w_hold_d  = '0;
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign out_valid  = w_send;
    assign out_last   = w_last;
    assign out_chunk  = w_send ? r_hold[HOLD_W-1 -: CHUNK_W] : '0;
    assign words_sent = r_words;

endmodule

// File: tb/tb_word_chunker.sv
// Randomised and directed bench for word_chunker against a queue-based chunk model.
module tb_word_chunker;

    localparam int W  = 64;
    localparam int C  = 5;
    localparam int N  = (W + C - 1) / C;
    localparam int HW = N * C;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_word = '0;
    logic [C-1:0]  out_chunk;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [CW-1:0] words_sent;

    word_chunker #(
        .WORD_W  (W),
        .CHUNK_W (C),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_chunk  (out_chunk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic         last;
        logic [C-1:0] chunk;
    } ent_t;

    // Model: pending chunks of the word in flight, plus completed-word count.
    ent_t          m_q[$];
    logic [CW-1:0] m_words = '0;

    function automatic void push_word(input logic [W-1:0] w);
        logic [HW-1:0] ext;
        ent_t e;
        ext = HW'(w);
        for (int k = 0; k < N; k++) begin
            e.last  = (k == N - 1);
            e.chunk = ext[HW-1-C*k -: C];
            m_q.push_back(e);
        end
    endfunction

    initial begin : compare
        bit   m_ready;
        bit   acc;
        ent_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_q.delete();
                m_words = '0;
            end
            m_ready = (m_q.size() == 0) || (m_q.size() == 1 && out_ready);
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check("out_chunk", 64'(out_chunk), (m_q.size() > 0) ? 64'(m_q[0].chunk) : 64'd0);
            check("out_last", 64'(out_last), (m_q.size() > 0) ? 64'(m_q[0].last) : 64'd0);
            check("words_sent", 64'(words_sent), 64'(m_words));
            @(posedge clk);
            if (!reset) begin
                acc = ((m_q.size() == 0) || (m_q.size() == 1 && out_ready)) && in_valid;
                if (m_q.size() > 0 && out_ready) begin
                    e = m_q.pop_front();
                    if (e.last) m_words = m_words + 1'b1;
                end
                if (acc) push_word(in_word);
            end
        end
    end

    // Capture of every valid chunk, with the cycle it appeared on.
    ent_t cap[$];
    int   cap_cyc[$];
    int   cyc = 0;
    int   rdy_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (!reset && out_valid) begin
            cap.push_back({out_last, out_chunk});
            cap_cyc.push_back(cyc);
            if (in_ready) rdy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_word  = w;
        tick();
        in_valid = 1'b0;
        in_word  = {$urandom, $urandom};
    endtask

    initial begin : stim
        int            base;
        int            rbase;
        logic [63:0]   sr;
        logic [W-1:0]  wa;
        logic [W-1:0]  wb;

        #22 reset = 1'b0;
        tick();
        tick();

        // All-ones word
        base = cap.size();
        send_one(64'hFFFF_FFFF_FFFF_FFFF);
        repeat (14) tick();
        check("t1_count", 64'(cap.size() - base), 64'd13);
        check("t1_chunk0", 64'(cap[base]), 64'({1'b0, 5'b01111}));
        check("t1_chunk6", 64'(cap[base+6]), 64'({1'b0, 5'b11111}));
        check("t1_chunk12", 64'(cap[base+12]), 64'({1'b1, 5'b11111}));
        check("t1_words", 64'(words_sent), 64'd1);
        check("t1_idle_valid", 64'(out_valid), 64'd0);
        check("t1_idle_chunk", 64'(out_chunk), 64'd0);

        // MSB and LSB set, fed through a 64-bit shift register model
        base = cap.size();
        send_one(64'h8000_0000_0000_0001);
        repeat (14) tick();
        check("t2_count", 64'(cap.size() - base), 64'd13);
        check("t2_chunk0", 64'(cap[base].chunk), 64'(5'b01000));
        check("t2_chunk6", 64'(cap[base+6].chunk), 64'd0);
        check("t2_chunk12", 64'(cap[base+12]), 64'({1'b1, 5'b00001}));
        sr = '0;
        for (int k = 0; k < N; k++) sr = {sr[58:0], cap[base+k].chunk};
        check("t2_shreg_top", 64'(sr[63:60]), 64'(4'b1000));

        // Back-to-back A then B; in_word changes before B's handshake
        wa = 64'h0123_4567_89AB_CDEF;
        wb = ~wa;
        base  = cap.size();
        rbase = rdy_cnt;
        in_valid = 1'b1;
        in_word  = wa;
        tick();
        in_word = wb;
        repeat (13) tick();
        in_valid = 1'b0;
        repeat (14) tick();
        check("t3_count", 64'(cap.size() - base), 64'd26);
        check("t3_span", 64'(cap_cyc[base+25] - cap_cyc[base]), 64'd25);
        check("t3_a_last", 64'(cap[base+12]), 64'({1'b1, 5'b01111}));
        check("t3_b_first", 64'(cap[base+13]), 64'({1'b0, 5'b01111}));
        check("t3_b_last", 64'(cap[base+25]), 64'({1'b1, 5'b10000}));
        check("t3_ready_pulses", 64'(rdy_cnt - rbase), 64'd2);
        check("t3_words", 64'(words_sent), 64'd4);

        // Three-cycle stall while chunk 5 is presented
        base = cap.size();
        send_one(64'hDEAD_BEEF_0BAD_F00D);
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (12) tick();
        check("t4_count", 64'(cap.size() - base), 64'd16);
        check("t4_words", 64'(words_sent), 64'd5);

        // Asynchronous reset mid-cycle during chunk 7
        send_one(64'h1357_9BDF_0246_8ACE);
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_chunk", 64'(out_chunk), 64'd0);
        check("t5_rst_words", 64'(words_sent), 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        base = cap.size();
        send_one(64'hF800_0000_0000_0000);
        repeat (14) tick();
        check("t5_count", 64'(cap.size() - base), 64'd13);
        check("t5_chunk0", 64'(cap[base]), 64'({1'b0, 5'b01111}));
        check("t5_words", 64'(words_sent), 64'd1);

        // Random traffic
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_word   = {$urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        // 256 back-to-back words wrap the counter
        #2 reset = 1'b1;
        #4 reset = 1'b0;
        tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 256 * N; i++) begin
            in_word = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        check("t6_before_wrap", 64'(words_sent), 64'd255);
        check("t6_last_shown", 64'(out_last), 64'd1);
        tick();
        check("t6_wrapped", 64'(words_sent), 64'd0);
        check("t6_idle", 64'(out_valid), 64'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
